// File: rtl/mvm_nnbit_pkcc.sv
// ---------------------------------------------------------------------------
// mvm_nnbit_pkcc -- streaming P-lane signed matrix-vector MAC engine.
//
// Each accepted beat carries one column of P signed N-bit g operands and one
// shared signed N-bit e operand. Lane p accumulates g[p]*e over K beats. On
// the K-th beat all P dot products are published together in the result
// register o. The accumulators then clear so the next vector can follow with
// no bubble.
//
// Parameters:
//   N   operand width (signed), N >= 2
//   K   beats per dot product, K >= 2
//   P   number of lanes, P >= 1
//   OW  per-lane result width, 2*N + $clog2(K) (derived)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      (MVM_FLUSH_EN only) end the vector early on this beat
//   in_valid   beat offered
//   in_ready   beat can be accepted
//   g_input    lane p operand at [p*N +: N]
//   e_input    shared operand
//   out_valid  o holds an unconsumed result
//   out_ready  consumer takes the result
//   o          lane p dot product at [p*OW +: OW]
//
// Optional feature macro: MVM_FLUSH_EN (adds the flush input).
// ---------------------------------------------------------------------------
module mvm_nnbit_pkcc #(
  parameter  int N  = 8,
  parameter  int K  = 3,
  parameter  int P  = 3,
  localparam int OW = 2*N + $clog2(K)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef MVM_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [P*N-1:0] g_input,
  input  logic [N-1:0]  e_input,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [P*OW-1:0] o
);

  localparam int CW = $clog2(K);

  logic [CW-1:0]        cnt;
  logic signed [OW-1:0] acc  [P];
  logic signed [2*N-1:0] prod [P];
  logic signed [OW-1:0] sum  [P];
  logic                 last_beat;
  logic                 accept;

`ifdef MVM_FLUSH_EN
  assign last_beat = (cnt == CW'(K-1)) || flush;
`else
  assign last_beat = (cnt == CW'(K-1));
`endif

  // Only the final beat can stall: it needs the result register, which is
  // busy while an unconsumed result sits there and is not being taken now.
  assign in_ready = !(last_beat && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: combinational blocks use blocking assignments and give every
  // output a value on every path, so no latch is inferred.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      // Both operands signed, so the 2N-bit context sign-extends them and
      // the product is full precision.
      prod[p] = $signed(g_input[p*N +: N]) * $signed(e_input);
      sum[p]  = acc[p] + {{(OW-2*N){prod[p][2*N-1]}}, prod[p]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the
  // accumulators are a handful of flops, so all of them are reset so a reset
  // mid-vector leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      o         <= '0;
      for (int p = 0; p < P; p++) acc[p] <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (last_beat) begin
          // A final beat overrides the consume above, so o reloads and
          // out_valid stays high for back-to-back results.
          for (int p = 0; p < P; p++) begin
            o[p*OW +: OW] <= sum[p];
            acc[p]        <= '0;
          end
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          for (int p = 0; p < P; p++) acc[p] <= sum[p];
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_nnbit_pkcc.sv
// ---------------------------------------------------------------------------
// tb_mvm_nnbit_pkcc -- self-checking bench for mvm_nnbit_pkcc (N=8 K=3 P=3).
// A cycle-level reference model in plain integer arithmetic predicts
// in_ready, out_valid and every lane of o; directed vectors are also checked
// against their known dot products.
// ---------------------------------------------------------------------------
module tb_mvm_nnbit_pkcc;

  localparam int N  = 8;
  localparam int K  = 3;
  localparam int P  = 3;
  localparam int OW = 2*N + $clog2(K);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [P*N-1:0]  g_input;
  logic [N-1:0]    e_input;
  logic            out_valid;
  logic            out_ready;
  logic [P*OW-1:0] o;
`ifdef MVM_FLUSH_EN
  logic            flush = 1'b0;
`endif

  always #5 clk = ~clk;

  mvm_nnbit_pkcc #(.N(N), .K(K), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MVM_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g_input   (g_input),
    .e_input   (e_input),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: beats so far, per-lane running sums, result.
  int  m_count;
  int  m_acc [P];
  int  m_o   [P];
  bit  m_valid;
  bit  m_accepted;

  // Current stimulus.
  int  cur_g [P];
  int  cur_e;
  bit  cur_v;
  bit  cur_or;

  // Directed data: lane rows over beats k=0..2, and shared e per beat.
  int G [P][K] = '{'{29, 74, -39}, '{67, -71, 56}, '{75, -45, 34}};
  int E [K]    = '{-38, -91, 47};

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(input int p);
    logic signed [OW-1:0] v;
    v = o[p*OW +: OW];
    return 64'(v);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(m_valid));
    for (int p = 0; p < P; p++)
      check($sformatf("%s_o%0d", tag, p), lane(p), 64'(m_o[p]));
  endtask

  // One clock: drive while clk is low, check in_ready, step the model at the
  // edge, check outputs 1 time unit later, return at the next falling edge.
  task automatic tick(input string tag);
    bit exp_ready;
    in_valid  = cur_v;
    out_ready = cur_or;
    e_input   = N'(cur_e);
    for (int p = 0; p < P; p++) g_input[p*N +: N] = N'(cur_g[p]);
    #1;
    exp_ready = !((m_count == K-1) && m_valid && !cur_or);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
    m_accepted = cur_v && exp_ready;
    @(posedge clk);
    if (m_valid && cur_or) m_valid = 1'b0;
    if (m_accepted) begin
      for (int p = 0; p < P; p++) m_acc[p] += cur_g[p] * cur_e;
      if (m_count == K-1) begin
        for (int p = 0; p < P; p++) begin
          m_o[p]   = m_acc[p];
          m_acc[p] = 0;
        end
        m_valid = 1'b1;
        m_count = 0;
      end else begin
        m_count++;
      end
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    cur_v = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    m_count = 0;
    m_valid = 1'b0;
    for (int p = 0; p < P; p++) begin
      m_acc[p] = 0;
      m_o[p]   = 0;
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  // Offer a beat until the model accepts it, bounded to 16 cycles.
  task automatic send_beat(input string tag);
    int tries = 0;
    cur_v = 1'b1;
    do begin
      tick(tag);
      tries++;
    end while (!m_accepted && tries < 16);
    if (!m_accepted) check({tag, "_accept_timeout"}, 64'(tries), 64'd0);
    cur_v = 1'b0;
  endtask

  task automatic send_directed(input string tag);
    for (int k = 0; k < K; k++) begin
      for (int p = 0; p < P; p++) cur_g[p] = G[p][k];
      cur_e = E[k];
      send_beat($sformatf("%s_b%0d", tag, k));
    end
  endtask

  task automatic check_basic(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_l0"}, lane(0), -64'sd9669);
    check({tag, "_l1"}, lane(1),  64'sd6547);
    check({tag, "_l2"}, lane(2),  64'sd2843);
  endtask

  initial begin
    cur_v = 1'b0; cur_or = 1'b1; cur_e = 0;
    for (int p = 0; p < P; p++) cur_g[p] = 0;
    g_input = '0; e_input = '0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    do_reset("reset");

    // Basic vector, result one cycle after the final beat.
    cur_or = 1'b1;
    send_directed("basic");
    check_basic("basic");

    // Back-to-back: six consecutive beats, two identical results.
    send_directed("b2b_a");
    check_basic("b2b_a");
    send_directed("b2b_b");
    check_basic("b2b_b");

    // Backpressure: result held, final beat stalls until out_ready rises.
    cur_or = 1'b0;
    for (int k = 0; k < K-1; k++) begin
      for (int p = 0; p < P; p++) cur_g[p] = G[p][k];
      cur_e = E[k];
      send_beat($sformatf("bp_b%0d", k));
    end
    for (int p = 0; p < P; p++) cur_g[p] = G[p][K-1];
    cur_e = E[K-1];
    cur_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("bp_stall");
      check("bp_stall_ready", 64'(in_ready), 64'd0);
      check_basic("bp_hold");
    end
    cur_or = 1'b1;
    tick("bp_release");
    check("bp_release_accepted", 64'(m_accepted), 64'd1);
    cur_v = 1'b0;
    check_basic("bp_second");
    tick("bp_drain");

    // Extremes: no wrap at full negative and mixed-sign corners.
    for (int k = 0; k < K; k++) begin
      for (int p = 0; p < P; p++) cur_g[p] = -128;
      cur_e = -128;
      send_beat("ext_neg");
    end
    for (int p = 0; p < P; p++) check($sformatf("ext_neg_l%0d", p), lane(p), 64'sd49152);
    for (int k = 0; k < K; k++) begin
      for (int p = 0; p < P; p++) cur_g[p] = 127;
      cur_e = -128;
      send_beat("ext_mix");
    end
    for (int p = 0; p < P; p++) check($sformatf("ext_mix_l%0d", p), lane(p), -64'sd48768);

    // Reset mid-vector drops partial sums; next vector exact.
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < P; p++) cur_g[p] = G[p][k];
      cur_e = E[k];
      send_beat("mid");
    end
    do_reset("mid_reset");
    send_directed("post_reset");
    check_basic("post_reset");

    // Randomized traffic with random valid and ready.
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < P; p++) cur_g[p] = int'($urandom_range(0, 255)) - 128;
      cur_e  = int'($urandom_range(0, 255)) - 128;
      cur_v  = 1'($urandom_range(0, 3) != 0);
      cur_or = 1'($urandom_range(0, 2) != 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
